// File: rtl/ev_occupancy_counter.sv
// Up/down occupancy counter for the EV lot tracker.
// Ports: Clock/Reset, Increase/Decrease, Load/LoadValue, ClearFlags -> Count, Full, Empty, Overflow, Underflow.
module ev_occupancy_counter #(
  parameter int WIDTH       = 3,
  parameter int MAX_COUNT   = 7,
  parameter int RESET_VALUE = 1,
  parameter int EDGE_MODE   = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Increase,
  input  logic             Decrease,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  input  logic             ClearFlags,
  output logic [WIDTH-1:0] Count,
  output logic             Full,
  output logic             Empty,
  output logic             Overflow,
  output logic             Underflow
);

  localparam logic [WIDTH-1:0] MaxC = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] RstC = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] One  = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             inc_q, dec_q;
  logic             inc_ev, dec_ev;

  // History is kept in both modes; level mode simply ignores it.
  generate
    if (EDGE_MODE != 0) begin : g_edge
      assign inc_ev = Increase & ~inc_q;
      assign dec_ev = Decrease & ~dec_q;
    end else begin : g_level
      assign inc_ev = Increase;
      assign dec_ev = Decrease;
    end
  endgenerate

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q & ~ClearFlags;
    unf_d   = unf_q & ~ClearFlags;
    if (Load) begin
      count_d = (LoadValue > MaxC) ? MaxC : LoadValue;
    end else if (inc_ev && dec_ev) begin
      count_d = count_q;
    end else if (inc_ev) begin
      // Error set wins over a same-cycle clear.
      if (count_q < MaxC) count_d = count_q + One;
      else                ovf_d   = 1'b1;
    end else if (dec_ev) begin
      if (count_q != '0) count_d = count_q - One;
      else               unf_d   = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count_q <= RstC;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      // Updated on Load cycles too, so a held level is not re-counted.
      inc_q   <= Increase;
      dec_q   <= Decrease;
    end
  end

  assign Count     = count_q;
  assign Full      = (count_q == MaxC);
  assign Empty     = (count_q == '0);
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;

endmodule

// File: tb/tb_ev_occupancy_counter.sv
// Bench for ev_occupancy_counter: vector table, corner sequences,
// and random stimulus against a reference model (3 configurations).
module tb_ev_occupancy_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inc = 1'b0;
  logic       dec = 1'b0;
  logic       load = 1'b0;
  logic [2:0] lv = 3'd0;
  logic       clr = 1'b0;

  logic [2:0] cnt [3];
  logic       full [3];
  logic       empt [3];
  logic       ovf [3];
  logic       unf [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // 0: edge mode, max 7; 1: level mode, max 7; 2: level mode, max 5
  ev_occupancy_counter #(.WIDTH(3), .MAX_COUNT(7),
    .RESET_VALUE(1), .EDGE_MODE(1)) u_a (
    .Clock(clk), .Reset(rst_n), .Increase(inc),
    .Decrease(dec), .Load(load), .LoadValue(lv),
    .ClearFlags(clr), .Count(cnt[0]), .Full(full[0]),
    .Empty(empt[0]), .Overflow(ovf[0]),
    .Underflow(unf[0]));

  ev_occupancy_counter #(.WIDTH(3), .MAX_COUNT(7),
    .RESET_VALUE(1), .EDGE_MODE(0)) u_b (
    .Clock(clk), .Reset(rst_n), .Increase(inc),
    .Decrease(dec), .Load(load), .LoadValue(lv),
    .ClearFlags(clr), .Count(cnt[1]), .Full(full[1]),
    .Empty(empt[1]), .Overflow(ovf[1]),
    .Underflow(unf[1]));

  ev_occupancy_counter #(.WIDTH(3), .MAX_COUNT(5),
    .RESET_VALUE(1), .EDGE_MODE(0)) u_c (
    .Clock(clk), .Reset(rst_n), .Increase(inc),
    .Decrease(dec), .Load(load), .LoadValue(lv),
    .ClearFlags(clr), .Count(cnt[2]), .Full(full[2]),
    .Empty(empt[2]), .Overflow(ovf[2]),
    .Underflow(unf[2]));

  // Reference model: occupancy as a plain integer
  int mx [3] = '{7, 7, 5};
  int em [3] = '{1, 0, 0};
  int mc [3];
  int mo [3];
  int mu [3];
  int mi [3];
  int md [3];

  always @(posedge clk or negedge rst_n) begin : model
    int ie, de, c, o, u;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        mc[k] <= 1; mo[k] <= 0; mu[k] <= 0;
        mi[k] <= 0; md[k] <= 0;
      end else begin
        ie = (inc && !(em[k] == 1 && mi[k] == 1)) ? 1 : 0;
        de = (dec && !(em[k] == 1 && md[k] == 1)) ? 1 : 0;
        c = mc[k];
        o = (mo[k] == 1 && !clr) ? 1 : 0;
        u = (mu[k] == 1 && !clr) ? 1 : 0;
        if (load) begin
          c = (int'(lv) > mx[k]) ? mx[k] : int'(lv);
        end else if (ie == 1 && de == 1) begin
          c = c;
        end else if (ie == 1) begin
          if (c >= mx[k]) o = 1; else c = c + 1;
        end else if (de == 1) begin
          if (c == 0) u = 1; else c = c - 1;
        end
        mc[k] <= c; mo[k] <= o; mu[k] <= u;
        mi[k] <= inc ? 1 : 0;
        md[k] <= dec ? 1 : 0;
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int k,
                         input int c, input int f,
                         input int e, input int o,
                         input int u);
    chk({nm, ".count"}, 32'(cnt[k]), c);
    chk({nm, ".full"},  32'(full[k]), f);
    chk({nm, ".empty"}, 32'(empt[k]), e);
    chk({nm, ".ovf"},   32'(ovf[k]), o);
    chk({nm, ".unf"},   32'(unf[k]), u);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit       i, d, ld;
    bit [2:0] v;
    bit       cl;
    int       c, f, e, o, u;
  } vec_t;

  vec_t tv [27];

  initial begin
    // inc dec load lv clr | count full empty ovf unf
    tv[0]  = '{1,0,0,0,0, 2,0,0,0,0};
    tv[1]  = '{1,0,0,0,0, 2,0,0,0,0};
    tv[2]  = '{1,0,0,0,0, 2,0,0,0,0};
    tv[3]  = '{1,0,0,0,0, 2,0,0,0,0};
    tv[4]  = '{0,0,0,0,0, 2,0,0,0,0};
    tv[5]  = '{1,0,0,0,0, 3,0,0,0,0};
    tv[6]  = '{0,0,0,0,0, 3,0,0,0,0};
    tv[7]  = '{1,0,0,0,0, 4,0,0,0,0};
    tv[8]  = '{0,0,0,0,0, 4,0,0,0,0};
    tv[9]  = '{1,0,0,0,0, 5,0,0,0,0};
    tv[10] = '{0,0,0,0,0, 5,0,0,0,0};
    tv[11] = '{0,0,1,7,0, 7,1,0,0,0};
    tv[12] = '{1,0,0,0,0, 7,1,0,1,0};
    tv[13] = '{0,0,0,0,1, 7,1,0,0,0};
    tv[14] = '{1,0,0,0,1, 7,1,0,1,0};
    tv[15] = '{0,0,1,0,0, 0,0,1,1,0};
    tv[16] = '{0,0,0,0,1, 0,0,1,0,0};
    tv[17] = '{0,1,0,0,0, 0,0,1,0,1};
    tv[18] = '{1,0,0,0,0, 1,0,0,0,1};
    tv[19] = '{0,0,1,3,1, 3,0,0,0,0};
    tv[20] = '{1,1,0,0,0, 3,0,0,0,0};
    tv[21] = '{0,0,0,0,0, 3,0,0,0,0};
    tv[22] = '{1,0,1,6,0, 6,0,0,0,0};
    tv[23] = '{1,0,0,0,0, 6,0,0,0,0};
    tv[24] = '{0,0,0,0,0, 6,0,0,0,0};
    tv[25] = '{0,1,0,0,0, 5,0,0,0,0};
    tv[26] = '{0,1,0,0,0, 5,0,0,0,0};

    // Reset state
    tick();
    tick();
    chk_all("rst", 0, 1, 0, 0, 0, 0);
    #2 rst_n = 1'b1;

    // Edge-mode vector table on instance 0
    foreach (tv[n]) begin
      inc = tv[n].i; dec = tv[n].d;
      load = tv[n].ld; lv = tv[n].v;
      clr = tv[n].cl;
      tick();
      chk_all($sformatf("vec%0d", n), 0, tv[n].c,
              tv[n].f, tv[n].e, tv[n].o, tv[n].u);
    end

    // Asynchronous reset mid-cycle from Count=5
    #2;
    rst_n = 1'b0;
    inc = 1'b0; dec = 1'b0;
    #1;
    chk_all("async_rst", 0, 1, 0, 0, 0, 0);
    inc = 1'b1;
    tick();
    chk("rst_hold.count", 32'(cnt[0]), 1);
    #2 rst_n = 1'b1;
    // Input already high counts as an edge after release
    tick();
    chk("rst_rel.count", 32'(cnt[0]), 2);
    inc = 1'b0;

    // Level mode: hold Increase from 4
    load = 1'b1; lv = 3'd4;
    tick();
    chk("lvl_load.count", 32'(cnt[1]), 4);
    load = 1'b0; inc = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk($sformatf("lvl%0d.count", s),
          32'(cnt[1]), 5 + s);
    end
    tick();
    chk_all("lvl_sat", 1, 7, 1, 0, 1, 0);
    inc = 1'b0;

    // Load clamps to MAX_COUNT=5
    load = 1'b1; lv = 3'd7; clr = 1'b1;
    tick();
    chk_all("clamp", 2, 5, 1, 0, 0, 0);
    chk("clamp_a.count", 32'(cnt[0]), 7);
    load = 1'b0; clr = 1'b0;

    // Randomized against the reference model
    for (int r = 0; r < 400; r++) begin
      inc  = ($urandom_range(0, 2) != 0);
      dec  = ($urandom_range(0, 2) == 0);
      load = ($urandom_range(0, 15) == 0);
      lv   = 3'($urandom_range(0, 7));
      clr  = ($urandom_range(0, 7) == 0);
      tick();
      for (int k = 0; k < 3; k++) begin
        chk_all($sformatf("rnd%0d.i%0d", r, k), k,
                mc[k], (mc[k] == mx[k]) ? 1 : 0,
                (mc[k] == 0) ? 1 : 0, mo[k], mu[k]);
      end
      if ($urandom_range(0, 63) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
